// File: rtl/distance_filter.sv
// Moving-average and hysteresis proximity filter for the ultrasonic ranger.
// Optional stall watchdog enabled by defining DIST_FILTER_STALE_EN.
module distance_filter #(
   parameter int DEPTH_LOG2 = 2,
   parameter int ENTER_CM   = 5,
   parameter int EXIT_CM    = 8,
   parameter int STALE_CLKS = 300_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sample_valid,
   input  logic [7:0] sample_cm,
   output logic [7:0] avg_cm,
   output logic       avg_valid,
   output logic       alarm,
   output logic       buf_full,
   output logic       stale,
   output logic [7:0] reject_cnt
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int SW    = 8 + DEPTH_LOG2;
   localparam int CW    = DEPTH_LOG2 + 1;

   localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
   localparam logic [CW-1:0]         CNT_ONE = 1;
   localparam logic [CW-1:0]         CNT_MAX = CW'(DEPTH);

   if (EXIT_CM <= ENTER_CM || STALE_CLKS < 1) begin : g_bad_cfg
      $error("distance_filter: bad thresholds or watchdog limit");
   end

   typedef enum logic [1:0] {
      IDLE,
      UPDATE,
      EMIT
   } state_t;

   state_t                state_q, state_d;
   logic [7:0]            mem_q [DEPTH];
   logic [SW-1:0]         sum_q, sum_d;
   logic [DEPTH_LOG2-1:0] wr_ptr_q;
   logic [CW-1:0]         count_q;
   logic [7:0]            avg_q;
   logic                  alarm_q, alarm_d;
   logic [7:0]            rej_q;
   logic                  full, accept, reject, expire;
   logic [SW-1:0]         add_w, old_w;
   logic [7:0]            avg_new;

   assign full    = (count_q == CNT_MAX);
   assign accept  = (state_q == IDLE) && sample_valid && (sample_cm != 8'd0);
   assign reject  = sample_valid && !accept;
   assign add_w   = SW'(sample_cm);
   assign old_w   = full ? SW'(mem_q[wr_ptr_q]) : '0;
   assign sum_d   = sum_q + add_w - old_w;
   assign avg_new = sum_q[SW-1:DEPTH_LOG2];

`ifdef DIST_FILTER_STALE_EN
   logic [31:0] wd_q;
   logic        stale_q;

   assign expire = !stale_q && !accept && (wd_q == 32'(STALE_CLKS - 1));
   assign stale  = stale_q;

   // Watchdog: restarted by accepted samples, latches stale on expiry
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wd_q    <= '0;
         stale_q <= 1'b0;
      end else if (accept) begin
         wd_q    <= '0;
         stale_q <= 1'b0;
      end else if (expire) begin
         wd_q    <= '0;
         stale_q <= 1'b1;
      end else if (!stale_q) begin
         wd_q    <= wd_q + 32'd1;
      end
   end
`else
   assign expire = 1'b0;
   assign stale  = 1'b0;
`endif

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next state, valid pulse and alarm hysteresis on the fresh average
   always_comb begin
      state_d   = state_q;
      avg_valid = 1'b0;
      alarm_d   = alarm_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = UPDATE;
         UPDATE:  state_d = full ? EMIT : IDLE;
         EMIT: begin
            state_d   = IDLE;
            avg_valid = 1'b1;
         end
         default: state_d = IDLE;
      endcase
      if (expire) begin
         alarm_d = 1'b0;
      end else if (state_q == UPDATE && full) begin
         if (!alarm_q && avg_new <= 8'(ENTER_CM))
            alarm_d = 1'b1;
         else if (alarm_q && avg_new >= 8'(EXIT_CM))
            alarm_d = 1'b0;
      end
   end

   // Window storage, running sum, average and reject counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         sum_q    <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         avg_q    <= '0;
         alarm_q  <= 1'b0;
         rej_q    <= '0;
      end else begin
         if (accept) begin
            mem_q[wr_ptr_q] <= sample_cm;
            sum_q           <= sum_d;
            wr_ptr_q        <= wr_ptr_q + PTR_ONE;
            if (!full) count_q <= count_q + CNT_ONE;
         end else if (expire) begin
            sum_q    <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
         end
         if (state_q == UPDATE && full) avg_q <= avg_new;
         alarm_q <= alarm_d;
         if (reject && rej_q != 8'hFF) rej_q <= rej_q + 8'd1;
      end
   end

   assign avg_cm     = avg_q;
   assign alarm      = alarm_q;
   assign buf_full   = full;
   assign reject_cnt = rej_q;

endmodule

// File: tb/tb_distance_filter.sv
// Scoreboard bench for distance_filter with directed sample vectors.
// Stale watchdog scenarios run only when DIST_FILTER_STALE_EN is defined.
module tb_distance_filter;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       sample_valid = 1'b0;
   logic [7:0] sample_cm = '0;
   logic [7:0] avg_cm;
   logic       avg_valid;
   logic       alarm;
   logic       buf_full;
   logic       stale;
   logic [7:0] reject_cnt;

   distance_filter #(
      .DEPTH_LOG2(2),
      .ENTER_CM  (5),
      .EXIT_CM   (8),
      .STALE_CLKS(100)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .sample_valid(sample_valid),
      .sample_cm   (sample_cm),
      .avg_cm      (avg_cm),
      .avg_valid   (avg_valid),
      .alarm       (alarm),
      .buf_full    (buf_full),
      .stale       (stale),
      .reject_cnt  (reject_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int avg;
      int al;
      int cyc;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   last_acc = 0;
   int   exp_rej = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d required %0d", nm, act, req);
      end
   endtask

   // Monitor: every avg_valid pulse must match the oldest expectation
   always @(negedge clk) begin
      if (avg_valid === 1'b1) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_avg_valid: got avg %0d required none",
                     avg_cm);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("avg_cm", 32'(avg_cm), e.avg);
            chk("alarm", 32'(alarm), e.al);
            chk("latency", cyc, e.cyc);
         end
      end
   end

   // Drive one strobe from a negedge; returns at the negedge 3 cycles later
   task automatic send(input int cm, input bit ev, input int ea,
                       input int eal, input bit ef);
      exp_t e;
      sample_valid = 1'b1;
      sample_cm    = 8'(cm);
      if (cm != 0) last_acc = cyc + 1;
      else if (exp_rej < 255) exp_rej++;
      if (ev) begin
         e.avg = ea;
         e.al  = eal;
         e.cyc = cyc + 2;
         q.push_back(e);
      end
      @(negedge clk);
      sample_valid = 1'b0;
      chk("buf_full", 32'(buf_full), 32'(ef));
      chk("reject_cnt", 32'(reject_cnt), exp_rej);
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic chk_reset_outs;
      chk("rst_avg_cm", 32'(avg_cm), 0);
      chk("rst_avg_valid", 32'(avg_valid), 0);
      chk("rst_alarm", 32'(alarm), 0);
      chk("rst_buf_full", 32'(buf_full), 0);
      chk("rst_stale", 32'(stale), 0);
      chk("rst_reject_cnt", 32'(reject_cnt), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: got no finish required finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      chk_reset_outs();
      reset = 1'b0;
      @(negedge clk);

      // Fill with 20s: first average after 4th sample
      send(20, 0, 0, 0, 0);
      send(20, 0, 0, 0, 0);
      send(20, 0, 0, 0, 0);
      send(20, 1, 20, 0, 1);
      // Descend into alarm region
      send(4, 1, 16, 0, 1);
      send(4, 1, 12, 0, 1);
      send(4, 1, 8, 0, 1);
      send(4, 1, 4, 1, 1);
      // In the hysteresis band the alarm holds
      send(7, 1, 4, 1, 1);
      send(7, 1, 5, 1, 1);
      send(20, 1, 9, 0, 1);
      send(20, 1, 13, 0, 1);
      send(2, 1, 12, 0, 1);
      send(2, 1, 11, 0, 1);
      send(2, 1, 6, 0, 1);
      send(2, 1, 2, 1, 1);

      // Accepted 9 followed by a strobe during UPDATE, then a zero
      sample_valid = 1'b1;
      sample_cm    = 8'd9;
      last_acc     = cyc + 1;
      q.push_back('{avg: 3, al: 1, cyc: cyc + 2});
      @(negedge clk);
      sample_cm = 8'd33;
      exp_rej++;
      @(negedge clk);
      sample_valid = 1'b0;
      chk("drop_cnt", 32'(reject_cnt), exp_rej);
      @(negedge clk);
      send(0, 0, 0, 0, 1);
      chk("reject_two", 32'(reject_cnt), 2);

      // Back-to-back zero strobes saturate the counter
      sample_valid = 1'b1;
      sample_cm    = 8'd0;
      repeat (300) @(negedge clk);
      sample_valid = 1'b0;
      exp_rej      = 255;
      @(negedge clk);
      chk("reject_sat", 32'(reject_cnt), 255);

      // Reset while in UPDATE after three more samples
      send(3, 1, 4, 1, 1);
      send(3, 1, 4, 1, 1);
      sample_valid = 1'b1;
      sample_cm    = 8'd3;
      @(negedge clk);
      sample_valid = 1'b0;
      reset        = 1'b1;
      #1;
      chk_reset_outs();
      @(negedge clk);
      reset   = 1'b0;
      exp_rej = 0;
      @(negedge clk);
      send(40, 0, 0, 0, 0);
      send(40, 0, 0, 0, 0);
      send(40, 0, 0, 0, 0);
      send(40, 1, 40, 0, 1);

`ifdef DIST_FILTER_STALE_EN
      send(3, 1, 30, 0, 1);
      send(3, 1, 21, 0, 1);
      send(3, 1, 12, 0, 1);
      send(3, 1, 3, 1, 1);
      while (cyc < last_acc + 99) @(negedge clk);
      chk("stale_early", 32'(stale), 0);
      @(negedge clk);
      chk("stale_set", 32'(stale), 1);
      chk("stale_alarm", 32'(alarm), 0);
      chk("stale_full", 32'(buf_full), 0);
      chk("stale_avg_hold", 32'(avg_cm), 3);
      repeat (5) @(negedge clk);
      sample_valid = 1'b1;
      sample_cm    = 8'd50;
      last_acc     = cyc + 1;
      @(negedge clk);
      sample_valid = 1'b0;
      chk("stale_clear", 32'(stale), 0);
      chk("refill_full", 32'(buf_full), 0);
      @(negedge clk);
      @(negedge clk);
      send(50, 0, 0, 0, 0);
      send(50, 0, 0, 0, 0);
      send(50, 1, 50, 0, 1);
      // Strobe lands in the exact expiry cycle
      while (cyc < last_acc + 99) @(negedge clk);
      send(10, 1, 40, 0, 1);
      chk("expiry_race", 32'(stale), 0);
      repeat (20) @(negedge clk);
      chk("expiry_after", 32'(stale), 0);
`else
      repeat (150) @(negedge clk);
      chk("no_stale", 32'(stale), 0);
      chk("no_clear", 32'(buf_full), 1);
`endif

      repeat (4) @(negedge clk);
      chk("sb_empty", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
